serial_sub_8bit: RTL and testbench

//  Bit-serial subtractor: computes D = A - B - BIN, one bit per clock, LSB first.

---
 rtl/serial_sub_8bit_if.sv | 24 ++
 rtl/serial_sub_8bit.sv | 121 ++++++++++++
 tb/tb_serial_sub_8bit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/serial_sub_8bit_if.sv
// Handshake and operand/result bundle between a controller and the bit-serial subtractor.
interface serial_sub_8bit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bo, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bo, ovf
  );
endinterface

// File: rtl/serial_sub_8bit.sv
// Bit-serial subtractor: D = A - B - BIN, one bit per clock LSB first through a single
// full-subtractor cell with a registered borrow.
module serial_sub_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_sub_8bit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               br_q,    br_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH-1:0]   b_q,     b_d;
  logic [WIDTH-1:0]   res_q,   res_d;
  logic [WIDTH-1:0]   d_q,     d_d;
  logic               bo_q,    bo_d;
  logic               ovf_q,   ovf_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic               ai_c, bi_c, di_c, br_nxt_c;

  // Full-subtractor cell on the bit selected by the counter.
  always_comb begin
    ai_c     = a_q[cnt_q];
    bi_c     = b_q[cnt_q];
    di_c     = ai_c ^ bi_c ^ br_q;
    br_nxt_c = (~ai_c & bi_c) | (~(ai_c ^ bi_c) & br_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    d_d     = d_q;
    bo_d    = bo_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_d = {di_c, res_q[WIDTH-1:1]};
        br_d  = br_nxt_c;
        cnt_d = CNT_W'(cnt_q + 1'b1);
        // Last bit: publish result; overflow uses the captured operand signs.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          d_d     = res_d;
          bo_d    = br_nxt_c;
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = d_q;
  assign bus.bo   = bo_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub_8bit.sv
// Directed and random checks of the bit-serial subtractor: latency, results, busy-start
// rejection and mid-operation reset.
module tb_serial_sub_8bit;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] last_d   = 8'h00;
  logic       last_bo  = 1'b0;
  logic       last_ovf = 1'b0;

  serial_sub_8bit_if #(.WIDTH(WIDTH)) bus ();

  serial_sub_8bit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation; glitch>0 re-pulses start with other operands in that busy cycle.
  task automatic op(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                    input logic bini, input logic [7:0] ed, input logic ebo,
                    input logic eovf, input int glitch);
    int k;
    @(negedge clk);
    bus.start = 1'b1; bus.a = ai; bus.b = bi; bus.bin = bini;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~ai; bus.b = ~bi; bus.bin = ~bini;
    chk({tag, "_busy_e0"}, 32'(bus.busy), 32'(1'b1));
    k = 0;
    while (k < WIDTH + 3) begin
      @(posedge clk); #1;
      k++;
      if (bus.start) begin
        bus.start = 1'b0; bus.a = ~ai; bus.b = ~bi;
      end
      if (bus.done) break;
      chk({tag, "_hold_d"}, 32'(bus.d), 32'(last_d));
      if (k == glitch) begin
        bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd2; bus.bin = 1'b0;
      end
    end
    chk({tag, "_latency"}, 32'(k), 32'(WIDTH));
    chk({tag, "_d"},       32'(bus.d),    32'(ed));
    chk({tag, "_bo"},      32'(bus.bo),   32'(ebo));
    chk({tag, "_ovf"},     32'(bus.ovf),  32'(eovf));
    chk({tag, "_busy_dn"}, 32'(bus.busy), 32'(1'b1));
    @(posedge clk); #1;
    chk({tag, "_done_1cy"}, 32'(bus.done), 32'(1'b0));
    chk({tag, "_busy_off"}, 32'(bus.busy), 32'(1'b0));
    last_d = ed; last_bo = ebo; last_ovf = eovf;
  endtask

  initial begin
    logic [7:0] ra, rb, rd;
    logic       rbin, rbo, rovf;
    logic [8:0] full;

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d",    32'(bus.d),    32'(8'h00));
    chk("rst_bo",   32'(bus.bo),   32'(1'b0));
    chk("rst_ovf",  32'(bus.ovf),  32'(1'b0));
    chk("rst_done", 32'(bus.done), 32'(1'b0));
    chk("rst_busy", 32'(bus.busy), 32'(1'b0));
    @(negedge clk); rst_n = 1'b1;

    op("t1",  8'd100, 8'd37,  1'b0, 8'd63,  1'b0, 1'b0, 0);
    op("t2",  8'd5,   8'd10,  1'b0, 8'hFB,  1'b1, 1'b0, 0);
    op("t3a", 8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1, 0);
    op("t3b", 8'h7F,  8'hFF,  1'b0, 8'h80,  1'b1, 1'b1, 0);
    op("t4a", 8'h00,  8'h00,  1'b1, 8'hFF,  1'b1, 1'b0, 0);
    op("t4b", 8'hFF,  8'hFF,  1'b1, 8'hFF,  1'b1, 1'b0, 0);
    op("t5",  8'd9,   8'd4,   1'b0, 8'd5,   1'b0, 1'b0, 3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t5_no_2nd_done", 32'(bus.done), 32'(1'b0));
      chk("t5_idle",        32'(bus.busy), 32'(1'b0));
    end

    // Abort with reset in the 4th busy cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h11; bus.bin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(bus.busy), 32'(1'b0));
    chk("t6_d",    32'(bus.d),    32'(8'h00));
    chk("t6_done", 32'(bus.done), 32'(1'b0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(posedge clk); #1;
      chk("t6_no_done", 32'(bus.done), 32'(1'b0));
    end
    last_d = 8'h00; last_bo = 1'b0; last_ovf = 1'b0;
    op("t6_new", 8'd200, 8'd100, 1'b0, 8'd100, 1'b0, 1'b1, 0);

    // Random back-to-back operations against the arithmetic reference.
    for (int i = 0; i < 12; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      full = {1'b0, ra} - {1'b0, rb} - 9'(rbin);
      rd   = full[7:0];
      rbo  = full[8];
      rovf = (ra[7] != rb[7]) && (rd[7] != ra[7]);
      op("rnd", ra, rb, rbin, rd, rbo, rovf, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
